// File: rtl/sid_pkg.sv
// Shared SID definitions: combined-waveform table selects and the default voice count.
package sid_pkg;

  typedef enum logic [1:0] {
    TSEL_ST  = 2'd0,
    TSEL_PT  = 2'd1,
    TSEL_PS  = 2'd2,
    TSEL_PST = 2'd3
  } tsel_t;

  localparam int NVOICES_DEF = 3;

endpackage

// File: rtl/sid_rr_arbiter.sv
// Combinational round-robin picker: first eligible requester after ptr, with wrap.
// Reusable by any shared SID resource (wave ROM, filter, envelope tables).
module sid_rr_arbiter #(
  parameter  int N  = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  eligible,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          any_grant
);

  // Priority distance of voice v is (v - ptr - 1) mod N; smallest eligible wins.
  always_comb begin
    int d;
    int best;
    best      = N;
    grant_idx = '0;
    for (int v = 0; v < N; v++) begin
      d = v - int'(ptr) - 1;
      if (d < 0) d = d + N;
      if (eligible[v] && d < best) begin
        best      = d;
        grant_idx = PW'(v);
      end
    end
    any_grant = (best < N);
    for (int v = 0; v < N; v++) begin
      grant[v] = any_grant && (grant_idx == PW'(v));
    end
  end

endmodule

// File: rtl/sid_wave_rom_arbiter.sv
// Shares one combined-waveform ROM port among the SID voices; a tag pipeline follows
// each lookup through the ROM latency and steers the result back with a one-cycle ack.
module sid_wave_rom_arbiter
  import sid_pkg::*;
#(
  parameter int NVOICES = NVOICES_DEF,
  parameter int ROM_LAT = 1,
  parameter int AW      = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NVOICES-1:0]    req,
  input  logic [NVOICES*AW-1:0] wave,
  input  logic [NVOICES*2-1:0]  tsel,
  output logic [AW-1:0]         rom_addr,
  output logic [1:0]            rom_tsel,
  input  logic [7:0]            rom_data,
  output logic [NVOICES-1:0]    ack,
  output logic [NVOICES*8-1:0]  out
);

  localparam int PW = $clog2(NVOICES);

  logic [NVOICES-1:0] pending;
  logic [NVOICES-1:0] eligible;
  logic [NVOICES-1:0] grant;
  logic [NVOICES-1:0] done;
  logic [PW-1:0]      ptr;
  logic [PW-1:0]      grant_idx;
  logic               any_grant;
  logic [AW-1:0]      sel_wave;
  tsel_t              sel_tsel;
  tsel_t              tsel_q;
  logic [ROM_LAT:0]   tag_valid;
  logic [PW-1:0]      tag_id [ROM_LAT+1];

  assign eligible = req & ~pending;
  assign rom_tsel = tsel_q;

  sid_rr_arbiter #(.N(NVOICES)) u_rr (
    .eligible  (eligible),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  always_comb begin
    sel_wave = '0;
    sel_tsel = TSEL_ST;
    for (int v = 0; v < NVOICES; v++) begin
      if (grant[v]) begin
        sel_wave = wave[v*AW +: AW];
        sel_tsel = tsel_t'(tsel[v*2 +: 2]);
      end
    end
  end

  // The oldest tag lines up with rom_data for the address issued ROM_LAT+1 edges ago.
  always_comb begin
    for (int v = 0; v < NVOICES; v++) begin
      done[v] = tag_valid[ROM_LAT] && (tag_id[ROM_LAT] == PW'(v));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rom_addr  <= '0;
      tsel_q    <= TSEL_ST;
      ack       <= '0;
      out       <= '0;
      pending   <= '0;
      ptr       <= PW'(NVOICES - 1);
      tag_valid <= '0;
      for (int i = 0; i <= ROM_LAT; i++) tag_id[i] <= '0;
    end else begin
      ack       <= done;
      // A voice cannot be granted and completed on the same edge: pending blocks it.
      pending   <= (pending & ~done) | grant;
      tag_valid <= {tag_valid[ROM_LAT-1:0], any_grant};
      tag_id[0] <= grant_idx;
      for (int i = 1; i <= ROM_LAT; i++) tag_id[i] <= tag_id[i-1];
      if (any_grant) begin
        rom_addr <= sel_wave;
        tsel_q   <= sel_tsel;
        ptr      <= grant_idx;
      end
      for (int v = 0; v < NVOICES; v++) begin
        if (done[v]) out[v*8 +: 8] <= rom_data;
      end
    end
  end

endmodule

// File: tb/tb_sid_wave_rom_arbiter.sv
// Bench for sid_wave_rom_arbiter: directed steps plus random traffic on a 3-voice/LAT1
// and a 4-voice/LAT3 instance, checked every cycle against a transaction-level model.
module tb_sid_wave_rom_arbiter;
  import sid_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [2:0]  req_a;
  logic [35:0] wave_a;
  logic [5:0]  tsel_a;
  logic [11:0] addr_a;
  logic [1:0]  rtsel_a;
  logic [7:0]  data_a = 8'h00;
  logic [2:0]  ack_a;
  logic [23:0] out_a;

  logic [3:0]  req_b;
  logic [47:0] wave_b;
  logic [7:0]  tsel_b;
  logic [11:0] addr_b;
  logic [1:0]  rtsel_b;
  logic [7:0]  data_b;
  logic [3:0]  ack_b;
  logic [31:0] out_b;
  logic [7:0]  rb [3];

  sid_wave_rom_arbiter #(.NVOICES(3), .ROM_LAT(1), .AW(12)) dut_a (
    .clock(clock), .reset(reset), .req(req_a), .wave(wave_a), .tsel(tsel_a),
    .rom_addr(addr_a), .rom_tsel(rtsel_a), .rom_data(data_a), .ack(ack_a), .out(out_a)
  );

  sid_wave_rom_arbiter #(.NVOICES(4), .ROM_LAT(3), .AW(12)) dut_b (
    .clock(clock), .reset(reset), .req(req_b), .wave(wave_b), .tsel(tsel_b),
    .rom_addr(addr_b), .rom_tsel(rtsel_b), .rom_data(data_b), .ack(ack_b), .out(out_b)
  );

  // Stand-in combined-waveform tables indexed by wave[11:1].
  function automatic logic [7:0] rom_fn(input logic [1:0] ts, input logic [10:0] idx);
    logic [7:0] lo;
    logic [7:0] r;
    lo = idx[7:0];
    case (ts)
      TSEL_PT: begin
        if (lo == 8'hFF) begin
          case (idx[10:8])
            3'd0:    r = 8'h07;
            3'd1:    r = 8'h3F;
            3'd7:    r = 8'hFF;
            default: r = 8'h7F;
          endcase
        end else begin
          r = lo & {idx[10:8], 5'h00};
        end
      end
      TSEL_ST: r = lo ^ idx[10:3];
      TSEL_PS: r = lo & idx[10:3];
      default: r = lo | idx[10:3];
    endcase
    return r;
  endfunction

  always @(posedge clock) begin
    data_a <= rom_fn(rtsel_a, addr_a[11:1]);
    rb[0]  <= rom_fn(rtsel_b, addr_b[11:1]);
    rb[1]  <= rb[0];
    rb[2]  <= rb[1];
  end
  assign data_b = rb[2];

  typedef struct {
    int         v;
    int         due;
    logic [7:0] val;
  } flight_t;

  bit          cur;
  int          n_v, lat, now;
  int          m_ptr;
  bit          m_pend [8];
  logic [7:0]  m_out [8];
  logic [7:0]  m_ack;
  logic [11:0] m_addr;
  logic [1:0]  m_tsel;
  flight_t     fl [$];
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic get_req(input int v);
    return cur ? req_b[v] : req_a[v];
  endfunction

  function automatic logic [11:0] get_wave(input int v);
    return cur ? wave_b[v*12 +: 12] : wave_a[v*12 +: 12];
  endfunction

  function automatic logic [1:0] get_tsel(input int v);
    return cur ? tsel_b[v*2 +: 2] : tsel_a[v*2 +: 2];
  endfunction

  task automatic set_voice(input int v, input logic r, input logic [11:0] w, input logic [1:0] t);
    if (cur) begin
      req_b[v] = r; wave_b[v*12 +: 12] = w; tsel_b[v*2 +: 2] = t;
    end else begin
      req_a[v] = r; wave_a[v*12 +: 12] = w; tsel_a[v*2 +: 2] = t;
    end
  endtask

  task automatic model_reset();
    m_ptr  = n_v - 1;
    m_ack  = '0;
    m_addr = '0;
    m_tsel = '0;
    for (int v = 0; v < 8; v++) begin
      m_pend[v] = 1'b0;
      m_out[v]  = '0;
    end
    fl.delete();
  endtask

  // One clock edge of the arbiter as seen from outside: finish due lookups, grant one.
  task automatic model_edge();
    bit pend_pre [8];
    int g;
    now++;
    if (reset) begin
      model_reset();
      return;
    end
    pend_pre = m_pend;
    m_ack = '0;
    for (int k = fl.size() - 1; k >= 0; k--) begin
      if (fl[k].due == now) begin
        m_out[fl[k].v]  = fl[k].val;
        m_ack[fl[k].v]  = 1'b1;
        m_pend[fl[k].v] = 1'b0;
        fl.delete(k);
      end
    end
    g = -1;
    for (int i = 1; i <= n_v; i++) begin
      int c;
      c = (m_ptr + i) % n_v;
      if (g < 0 && get_req(c) && !pend_pre[c]) g = c;
    end
    if (g >= 0) begin
      m_addr    = get_wave(g);
      m_tsel    = get_tsel(g);
      m_pend[g] = 1'b1;
      m_ptr     = g;
      fl.push_back('{v: g, due: now + 1 + lat, val: rom_fn(m_tsel, m_addr[11:1])});
    end
  endtask

  task automatic check_all();
    logic [63:0] eo;
    eo = '0;
    for (int v = 0; v < n_v; v++) eo[v*8 +: 8] = m_out[v];
    if (cur) begin
      chk("b_rom_addr", {52'b0, addr_b}, {52'b0, m_addr});
      chk("b_rom_tsel", {62'b0, rtsel_b}, {62'b0, m_tsel});
      chk("b_ack", {60'b0, ack_b}, {56'b0, m_ack});
      chk("b_out", {32'b0, out_b}, eo);
    end else begin
      chk("a_rom_addr", {52'b0, addr_a}, {52'b0, m_addr});
      chk("a_rom_tsel", {62'b0, rtsel_a}, {62'b0, m_tsel});
      chk("a_ack", {61'b0, ack_a}, {56'b0, m_ack});
      chk("a_out", {40'b0, out_a}, eo);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    model_edge();
    check_all();
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    tick();
    reset = 1'b0;
  endtask

  task automatic renew_on_ack(input int v);
    if (m_ack[v]) set_voice(v, 1'b1, 12'($urandom), 2'($urandom));
  endtask

  task automatic rand_stim();
    for (int v = 0; v < n_v; v++) begin
      if (!get_req(v) || m_ack[v])
        set_voice(v, ($urandom_range(99) < 60), 12'($urandom), 2'($urandom));
      else if ($urandom_range(99) < 5)
        set_voice(v, 1'b0, get_wave(v), get_tsel(v));
    end
  endtask

  initial begin
    int cnt [4];
    int n, first, second, seen;
    logic [11:0] w0;

    req_a = '0; wave_a = '0; tsel_a = '0;
    req_b = '0; wave_b = '0; tsel_b = '0;
    cur = 1'b0; n_v = 3; lat = 1; now = 0;
    model_reset();

    #2 reset = 1'b1;
    #1;
    chk("rst_addr_a", {52'b0, addr_a}, 64'h0);
    chk("rst_ack_a", {61'b0, ack_a}, 64'h0);
    chk("rst_out_a", {40'b0, out_a}, 64'h0);
    chk("rst_ack_b", {60'b0, ack_b}, 64'h0);
    chk("rst_out_b", {32'b0, out_b}, 64'h0);
    tick();
    tick();
    reset = 1'b0;

    // Single voice lookup
    set_voice(0, 1'b1, 12'h1FE, 2'd1);
    tick();
    chk("t1_addr", {52'b0, addr_a}, 64'h1FE);
    tick();
    chk("t1_ack_early", {61'b0, ack_a}, 64'h0);
    tick();
    chk("t1_ack", {61'b0, ack_a}, 64'h1);
    chk("t1_out", {56'b0, out_a[7:0]}, 64'h07);
    set_voice(0, 1'b0, 12'h1FE, 2'd1);
    tick();
    chk("t1_ack_end", {61'b0, ack_a}, 64'h0);
    drain(2);

    // All three at once
    pulse_reset();
    set_voice(0, 1'b1, 12'hFFE, 2'd1);
    set_voice(1, 1'b1, 12'h3FE, 2'd1);
    set_voice(2, 1'b1, 12'h200, 2'd1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k >= 3) begin
        chk($sformatf("t2_ack%0d", k - 3), {61'b0, ack_a}, 64'h1 << (k - 3));
        chk($sformatf("t2_out%0d", k - 3), {56'b0, out_a[(k-3)*8 +: 8]},
            (k == 3) ? 64'hFF : (k == 4) ? 64'h3F : 64'h00);
      end
      for (int v = 0; v < 3; v++) if (m_ack[v]) set_voice(v, 1'b0, get_wave(v), 2'd1);
    end
    drain(2);

    // Fairness under continuous requests
    for (int v = 0; v < 4; v++) cnt[v] = 0;
    for (int v = 0; v < 3; v++) set_voice(v, 1'b1, 12'($urandom), 2'($urandom));
    for (int k = 0; k < 30; k++) begin
      tick();
      for (int v = 0; v < 3; v++) begin
        cnt[v] += int'(ack_a[v]);
        renew_on_ack(v);
      end
    end
    begin
      int mx, mn;
      mx = cnt[0]; mn = cnt[0];
      for (int v = 1; v < 3; v++) begin
        if (cnt[v] > mx) mx = cnt[v];
        if (cnt[v] < mn) mn = cnt[v];
      end
      chk("t3_fair_spread", 64'(mx - mn <= 1), 64'h1);
      chk("t3_total_acks", 64'(cnt[0] + cnt[1] + cnt[2]), 64'd28);
    end
    req_a = '0;
    drain(4);

    // Request held through its own ack
    n = 0;
    set_voice(1, 1'b1, 12'($urandom), 2'($urandom));
    for (int k = 0; k < 12; k++) begin
      tick();
      n += int'(ack_a[1]);
      renew_on_ack(1);
    end
    chk("t4_acks", 64'(n), 64'd4);
    req_a = '0;
    drain(3);

    // Reset with two lookups in flight
    w0 = 12'($urandom);
    set_voice(0, 1'b1, w0, 2'd1);
    set_voice(1, 1'b1, 12'($urandom), 2'd2);
    tick();
    tick();
    reset = 1'b1;
    #1;
    model_reset();
    chk("t5_rst_ack", {61'b0, ack_a}, 64'h0);
    chk("t5_rst_out", {40'b0, out_a}, 64'h0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("t5_first_grant", {52'b0, addr_a}, {52'b0, w0});
    chk("t5_no_ack0", {61'b0, ack_a}, 64'h0);
    tick();
    chk("t5_no_ack1", {61'b0, ack_a}, 64'h0);
    req_a = '0;
    drain(4);

    for (int k = 0; k < 300; k++) begin
      rand_stim();
      tick();
    end
    req_a = '0;
    drain(4);

    // Four voices, ROM_LAT=3
    cur = 1'b1; n_v = 4; lat = 3;
    pulse_reset();
    seen = 0;
    set_voice(2, 1'b1, 12'($urandom), 2'($urandom));
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (seen == 0 && ack_b[2]) begin
        seen = k;
        set_voice(2, 1'b0, get_wave(2), get_tsel(2));
      end
    end
    chk("b_latency", 64'(seen - 1), 64'd4);
    drain(2);

    first = 0; second = 0;
    for (int v = 0; v < 4; v++) set_voice(v, 1'b1, 12'($urandom), 2'($urandom));
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (ack_b[0]) begin
        if (first == 0) first = k;
        else if (second == 0) second = k;
      end
      for (int v = 0; v < 4; v++) renew_on_ack(v);
    end
    chk("b_regrant_period", 64'(second - first), 64'd5);
    req_b = '0;
    drain(6);

    for (int k = 0; k < 200; k++) begin
      rand_stim();
      tick();
    end
    req_b = '0;
    drain(6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sid_wave_rom_arbiter.md
Name: sid_wave_rom_arbiter

Overview:
Time-multiplexes one shared combined-waveform ROM port among the SID voices. The shared port covers the S+T, P+T, P+S and P+S+T tables, which are registered and indexed by wave[11:1]. Each voice raises a request with its 12-bit wave value and table select. The arbiter grants round-robin, drives the shared address/select, tracks in-flight lookups through the ROM latency, and returns each 8-bit result to its voice with a one-cycle ack. It sits between the voice generators and the shared ROM bank, so one set of ROMs serves all voices.

Parameters:
NVOICES, 3, number of requesting voices (2..8)
ROM_LAT, 1, clock edges from rom_addr/rom_tsel change to valid rom_data (1..4)
AW, 12, wave value width

Ports:
clock  in  1  system clock, all logic on posedge
reset  in  1  asynchronous, active-high; clears all state
req  in  NVOICES  per-voice lookup request (level)
wave  in  NVOICES*AW  per-voice wave value, voice v at [v*AW +: AW]
tsel  in  NVOICES*2  per-voice table: 0=S+T 1=P+T 2=P+S 3=P+S+T
rom_addr  out  AW  wave value of granted voice, to shared ROM bank
rom_tsel  out  2  table select of granted voice, to ROM output mux
rom_data  in  8  selected ROM output, valid ROM_LAT edges after address
ack  out  NVOICES  one-cycle pulse: result for voice v is valid on out
out  out  NVOICES*8  per-voice result register, voice v at [v*8 +: 8]

Behaviour:
- Reset values (async assert): rom_addr=0, rom_tsel=0, ack=0, out=0, pending=0, pipeline valid=0, rr pointer=NVOICES-1 (voice 0 has first priority).
- Eligible voice: req[v]=1 and pending[v]=0.
- Arbitration at each edge: search from (ptr+1) mod NVOICES upward with wrap. The first eligible voice g is granted.
- On grant: rom_addr<=wave[g], rom_tsel<=tsel[g], pending[g]<=1, ptr<=g. Push {valid=1, id=g} into tag shift register of depth ROM_LAT+1.
- No eligible voice: rom_addr/rom_tsel hold; push {valid=0}.
- At most one grant per cycle. Grants issue back-to-back with no bubbles.
- Tag exits shift register valid with id v at the same edge rom_data is valid:
  - out[v]<=rom_data; ack[v]<=1 for exactly one cycle.
  - pending[v]<=0.
- Latency: req sampled at grant edge E0; ack and out visible after edge E0+1+ROM_LAT (E2 for ROM_LAT=1).
- Requester holds wave/tsel stable from req rise until ack is seen. The arbiter captures them at the grant edge, so later changes are harmless but documented as illegal.
- req still high in the ack cycle counts as a new request. It is eligible from the next edge, because pending clears at the ack edge and that edge cannot also grant v.
- req dropped while pending: the lookup still completes and ack still pulses. The requester ignores it.
- out[v] holds its value between acks.
- Throughput: all NVOICES can be in flight simultaneously. With continuous req on all voices, grants rotate 0,1,..,NVOICES-1. Each voice re-grants every max(NVOICES, ROM_LAT+2) cycles.
- Reset mid-operation: in-flight lookups are discarded. No ack is issued for them after reset release.

Decomposition:
- Shared package sid_pkg: table-select constants (TSEL_ST=0, TSEL_PT=1, TSEL_PS=2, TSEL_PST=3) and the voice-count default.
- One natural sub-module: sid_rr_arbiter. It takes eligible[NVOICES] and ptr, and returns grant one-hot, grant index and any_grant. It is combinational and reusable by other shared SID resources (filter, envelope tables).
- Tag pipeline and pending bookkeeping stay in the top.

Test Plan:
Bench ROM model for tsel=1 uses the P+T table, out <= T[wave[11:1]], ROM_LAT=1.
1. Single voice: req[0]=1, wave=12'h1FE, tsel=1. Expect rom_addr=12'h1FE after E0, ack[0] pulse after E2, out[0]=8'h07, pending[0] cleared.
2. All three voices raised at once:
   - Stimulus: wave0=12'hFFE, wave1=12'h3FE, wave2=12'h200, all tsel=1.
   - Grants in order 0,1,2. ack[0], ack[1], ack[2] on consecutive cycles.
   - out = 8'hFF, 8'h3F, 8'h00.
3. Fairness: all req held high for 30 cycles. Grant sequence strictly 0,1,2 repeating. No voice granted while its pending bit is set. Per-voice ack count differs by at most 1.
4. Req held after ack: voice 1 keeps req=1. No grant to voice 1 at its ack edge; re-granted at the next edge when otherwise idle. Exactly one ack per grant.
5. Reset mid-flight: assert reset one cycle after granting voices 0 and 1. All ack=0 and out=0 immediately. No acks after release. The next grant goes to voice 0.
6. Latency variant ROM_LAT=3, NVOICES=4:
   - Single request: ack appears after edge E0+4.
   - All four requesting: four grants in four consecutive cycles. Each voice re-granted every 5 cycles.
   - Results correct per voice id.
